instr_fetch_decode: RTL and testbench

- Upstream stage of pc_controller.
- Fetches the 16-bit instruction at the current PC from instruction memory over a req/ack handshake and holds it in an instruction register (IR).
- Decodes IR into PL/JB/BC, the sign-extended branch_offset and register-field selects.
- Issues a one-cycle pc_enable per completed instruction, which gates PC update in pc_controller.

---
 rtl/simple_cpu_pkg.sv | 58 +++++
 rtl/instr_decoder.sv | 55 +++++
 rtl/instr_fetch_decode.sv | 151 +++++++++++++++
 tb/tb_instr_fetch_decode.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simple_cpu_pkg
// Description : Shared opcode, field-position and FSM encodings for the
//               fetch/decode front end (legal list used by ILLEGAL_OP_TRAP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
package simple_cpu_pkg;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 9;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int DR_MSB     = 8;
  localparam int DR_LSB     = 6;
  localparam int SA_MSB     = 5;
  localparam int SA_LSB     = 3;
  localparam int SB_MSB     = 2;
  localparam int SB_LSB     = 0;

  localparam logic [OPCODE_W-1:0] OP_NOP = 7'b0000000;
  localparam logic [OPCODE_W-1:0] OP_ADD = 7'b0000010;
  localparam logic [OPCODE_W-1:0] OP_SUB = 7'b0000101;
  localparam logic [OPCODE_W-1:0] OP_LD  = 7'b0010000;
  localparam logic [OPCODE_W-1:0] OP_ST  = 7'b0100000;
  localparam logic [OPCODE_W-1:0] OP_BRZ = 7'b1100000;
  localparam logic [OPCODE_W-1:0] OP_BRN = 7'b1100001;
  localparam logic [OPCODE_W-1:0] OP_JMP = 7'b1110000;

  localparam int NUM_LEGAL_OPS = 8;
  localparam logic [OPCODE_W-1:0] LEGAL_OPS [NUM_LEGAL_OPS] = '{
    OP_NOP, OP_ADD, OP_SUB, OP_LD, OP_ST, OP_BRZ, OP_BRN, OP_JMP
  };

  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_LEGAL_OPS; i++) begin
      if (op == LEGAL_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_WAIT  = ST_WAIT,
    S_EXEC  = ST_EXEC,
    S_FAULT = ST_FAULT
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_decoder
// Description : Combinational IR decode: branch controls, sign-extended
//               offset, register selects; illegal flag with ILLEGAL_OP_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder
  import simple_cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] ir,
  output logic              pl,
  output logic              jb,
  output logic              bc,
  output logic [DATA_W-1:0] branch_offset,
  output logic [2:0]        dr,
  output logic [2:0]        sa,
  output logic [2:0]        sb
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic              illegal
`endif
);

  logic [OPCODE_W-1:0] w_opcode;

  assign w_opcode = ir[OPCODE_MSB:OPCODE_LSB];

  always_comb begin
    pl = 1'b0;
    jb = 1'b0;
    bc = 1'b0;
    case (w_opcode)
      OP_BRZ:  pl = 1'b1;
      OP_BRN:  begin pl = 1'b1; bc = 1'b1; end
      OP_JMP:  begin pl = 1'b1; jb = 1'b1; end
      default: ;
    endcase
  end

  // Offset is {DR,SB}; DR's top bit doubles as the sign bit.
  assign branch_offset = {{(DATA_W-6){ir[DR_MSB]}}, ir[DR_MSB:DR_LSB], ir[SB_MSB:SB_LSB]};

  assign dr = ir[DR_MSB:DR_LSB];
  assign sa = ir[SA_MSB:SA_LSB];
  assign sb = ir[SB_MSB:SB_LSB];

`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal = ~is_legal_op(w_opcode);
`endif

endmodule
`default_nettype wire

// File: rtl/instr_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_decode
// Description : Fetches instructions over req/ack into IR, decodes them and
//               strobes pc_enable once per instruction; ILLEGAL_OP_TRAP_EN
//               adds an illegal-opcode trap into FAULT.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_decode
  import simple_cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              imem_ack,
  output logic [DATA_W-1:0] ir,
  output logic [2:0]        dr,
  output logic [2:0]        sa,
  output logic [2:0]        sb,
  output logic              PL,
  output logic              JB,
  output logic              BC,
  output logic [DATA_W-1:0] branch_offset,
  output logic              exec_valid,
  output logic              pc_enable,
  output logic              fetch_fault
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic              illegal_op
`endif
);

  localparam int         CNT_W   = 8;
  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

  state_t              r_state;
  logic [DATA_W-1:0]   r_ir;
  logic [DATA_W-1:0]   r_addr;
  logic                r_req;
  logic                r_exec;
  logic                r_pcen;
  logic                r_fault;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_pl;
  logic                w_jb;
  logic                w_bc;
  logic                w_gate;
`ifdef ILLEGAL_OP_TRAP_EN
  logic                w_illegal;
  logic                r_illegal;
`endif

  instr_decoder #(.DATA_W(DATA_W)) u_decoder (
    .ir            (r_ir),
    .pl            (w_pl),
    .jb            (w_jb),
    .bc            (w_bc),
    .branch_offset (branch_offset),
    .dr            (dr),
    .sa            (sa),
    .sb            (sb)
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    .illegal       (w_illegal)
`endif
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_addr  <= '0;
      r_req   <= 1'b0;
      r_exec  <= 1'b0;
      r_pcen  <= 1'b0;
      r_fault <= 1'b0;
      r_cnt   <= '0;
`ifdef ILLEGAL_OP_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          r_addr  <= pc;
          r_req   <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // An ack on the final allowed cycle still completes normally.
          if (imem_ack) begin
            r_ir    <= imem_data;
            r_req   <= 1'b0;
            r_exec  <= 1'b1;
            r_pcen  <= 1'b1;
            r_state <= S_EXEC;
          end else if (r_cnt == c_timeout) begin
            r_fault <= 1'b1;
            r_req   <= 1'b0;
            r_state <= S_FAULT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          r_exec <= 1'b0;
          r_pcen <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
          if (w_illegal) begin
            r_illegal <= 1'b1;
            r_state   <= S_FAULT;
          end else begin
            r_state <= S_FETCH;
          end
`else
          r_state <= S_FETCH;
`endif
        end
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  assign w_gate     = r_exec & ~w_illegal;
  assign pc_enable  = r_pcen & ~w_illegal;
  assign illegal_op = r_illegal;
`else
  assign w_gate     = r_exec;
  assign pc_enable  = r_pcen;
`endif

  assign PL          = w_pl & w_gate;
  assign JB          = w_jb & w_gate;
  assign BC          = w_bc & w_gate;
  assign ir          = r_ir;
  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign exec_valid  = r_exec;
  assign fetch_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_decode
// Description : Self-checking bench: vector table, randomized instructions
//               against a reference decoder, and multi-cycle corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_decode;

  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_ack;
  logic [15:0] ir;
  logic [2:0]  dr, sa, sb;
  logic        PL, JB, BC;
  logic [15:0] branch_offset;
  logic        exec_valid, pc_enable, fetch_fault;
`ifdef ILLEGAL_OP_TRAP_EN
  logic        illegal_op;
`endif

  int n_total = 0;
  int n_pass  = 0;
  logic [15:0] prev_ir;

  instr_fetch_decode #(.DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_ack(imem_ack),
    .ir(ir), .dr(dr), .sa(sa), .sb(sb),
    .PL(PL), .JB(JB), .BC(BC), .branch_offset(branch_offset),
    .exec_valid(exec_valid), .pc_enable(pc_enable), .fetch_fault(fetch_fault)
`ifdef ILLEGAL_OP_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        pl, jb, bc;
    logic [15:0] off;
  } dec_t;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] data;
    int          delay;
    logic        pl, jb, bc;
    logic [15:0] off;
  } vec_t;

  // Reference decode straight from the opcode values and offset rule.
  function automatic dec_t ref_decode(input logic [15:0] w);
    dec_t r;
    int op, raw;
    op  = int'(w) / 512;
    raw = ((int'(w) / 64) % 8) * 8 + (int'(w) % 8);
    if (raw >= 32) raw = raw - 64;
    r.off = 16'(raw);
    r.pl  = (op == 96) || (op == 97) || (op == 112);
    r.jb  = (op == 112);
    r.bc  = (op == 97);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_req(output logic ok);
    int n = 0;
    do begin @(negedge clock); n++; end while (imem_req !== 1'b1 && n < 8);
    ok = (imem_req === 1'b1);
    if (!ok) chk("fetch_req_seen", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    imem_ack = 1'b0;
    #1 chk("reset_req_async", {31'd0, imem_req}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    chk("reset_ir", {16'd0, ir}, 32'd0);
    chk("reset_outs", {27'd0, exec_valid, pc_enable, fetch_fault, PL, imem_req}, 32'd0);
    chk("reset_addr", {16'd0, imem_addr}, 32'd0);
    reset = 1'b1;
    prev_ir = 16'h0000;
  endtask

  // Called from a negedge before the FETCH edge; returns in the next FETCH cycle.
  task automatic transact(input logic [15:0] pcv, input logic [15:0] data, input int delay,
                          input logic epl, input logic ejb, input logic ebc,
                          input logic [15:0] eoff, input logic epcen);
    logic ok;
    int   bad = 0;
    pc = pcv;
    wait_req(ok);
    if (!ok) return;
    chk("addr_latch", {16'd0, imem_addr}, {16'd0, pcv});
    chk("ir_hold", {16'd0, ir}, {16'd0, prev_ir});
    chk("wait_no_exec", {30'd0, exec_valid, pc_enable}, 32'd0);
    for (int k = 0; k <= delay; k++) begin
      if (k > 0) @(negedge clock);
      if (imem_req !== 1'b1 || imem_addr !== pcv || dr !== prev_ir[8:6]) bad++;
      if (k == delay) begin imem_ack = 1'b1; imem_data = data; end
      else imem_data = 16'($urandom);
    end
    chk("req_held", bad, 0);
    @(negedge clock);
    imem_ack = 1'b0;
    imem_data = 16'($urandom);
    chk("exec_valid", {31'd0, exec_valid}, 32'd1);
    chk("pc_enable", {31'd0, pc_enable}, {31'd0, epcen});
    chk("pl_jb_bc", {29'd0, PL, JB, BC}, {29'd0, epl, ejb, ebc});
    chk("offset", {16'd0, branch_offset}, {16'd0, eoff});
    chk("ir", {16'd0, ir}, {16'd0, data});
    chk("fields", {23'd0, dr, sa, sb}, {23'd0, data[8:0]});
    chk("req_drop", {30'd0, imem_req, fetch_fault}, 32'd0);
    @(negedge clock);
    chk("exec_one_cycle", {29'd0, exec_valid, pc_enable, PL}, 32'd0);
    prev_ir = data;
  endtask

  vec_t vecs[7];

  initial begin
    logic ok;
    int   bad;
    dec_t d;
    logic [15:0] w;
    reset = 1'b0; pc = '0; imem_data = '0; imem_ack = 1'b0; prev_ir = '0;

    vecs[0] = '{16'h0000, 16'hC1C5, 0,       1'b1, 1'b0, 1'b0, 16'hFFFD};
    vecs[1] = '{16'h0040, 16'hE000, 5,       1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[2] = '{16'h0041, 16'hC3C5, 1,       1'b1, 1'b0, 1'b1, 16'hFFFD};
    vecs[3] = '{16'h1234, 16'h0000, 2,       1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{16'hFFFF, 16'hC07A, 0,       1'b1, 1'b0, 1'b0, 16'h000A};
    vecs[5] = '{16'h0100, 16'hE1C0, TIMEOUT, 1'b1, 1'b1, 1'b0, 16'hFFF8};
    vecs[6] = '{16'h0002, 16'h01FF, 3,       1'b0, 1'b0, 1'b0, 16'hFFFF};

    do_reset();
    for (int i = 0; i < 7; i++)
      transact(vecs[i].pc, vecs[i].data, vecs[i].delay,
               vecs[i].pl, vecs[i].jb, vecs[i].bc, vecs[i].off, 1'b1);

    for (int i = 0; i < 25; i++) begin
      w = 16'($urandom);
      case ($urandom_range(0, 4))
        0: w[15:9] = 7'b1100000;
        1: w[15:9] = 7'b1100001;
        2: w[15:9] = 7'b1110000;
`ifdef ILLEGAL_OP_TRAP_EN
        default: w[15:9] = 7'b0000000;
`else
        default: ;
`endif
      endcase
      d = ref_decode(w);
      transact(16'($urandom), w, ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 4),
               d.pl, d.jb, d.bc, d.off, 1'b1);
    end

    // No ack at all: fault after the last allowed WAIT cycle, then dead.
    pc = 16'h0300;
    wait_req(ok);
    bad = 0;
    for (int k = 0; k <= TIMEOUT; k++) begin
      if (k > 0) @(negedge clock);
      if (imem_req !== 1'b1 || fetch_fault !== 1'b0) bad++;
    end
    chk("timeout_wait", bad, 0);
    @(negedge clock);
    chk("fetch_fault", {31'd0, fetch_fault}, 32'd1);
    chk("fault_req", {30'd0, imem_req, exec_valid}, 32'd0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      imem_ack = k[0];
      imem_data = 16'hE000;
      @(negedge clock);
      if (pc_enable || imem_req || exec_valid || !fetch_fault) bad++;
    end
    imem_ack = 1'b0;
    chk("fault_terminal", bad, 0);

    do_reset();
    transact(16'h0500, 16'hE1C0, 1, 1'b1, 1'b1, 1'b0, 16'hFFF8, 1'b1);

    // Reset mid-WAIT, then an ack while the FSM restarts.
    pc = 16'h0200;
    wait_req(ok);
    reset = 1'b0;
    #1;
    chk("midwait_req_drop", {31'd0, imem_req}, 32'd0);
    chk("midwait_ir_clear", {16'd0, ir}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_data = 16'hE000;
    @(negedge clock);
    imem_ack = 1'b0;
    chk("stale_ack_ir", {16'd0, ir}, 32'd0);
    chk("stale_ack_exec", {29'd0, exec_valid, pc_enable, PL}, 32'd0);
    prev_ir = 16'h0000;
    transact(16'h0600, 16'hC3C5, 0, 1'b1, 1'b0, 1'b1, 16'hFFFD, 1'b1);

    // Unknown opcode.
`ifdef ILLEGAL_OP_TRAP_EN
    transact(16'h0700, 16'hFE00, 1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("illegal_op", {31'd0, illegal_op}, 32'd1);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (imem_req || pc_enable || exec_valid) bad++;
    end
    chk("illegal_fault", bad, 0);
`else
    transact(16'h0700, 16'hFE00, 1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    transact(16'h0701, 16'hC07A, 0, 1'b1, 1'b0, 1'b0, 16'h000A, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire
